// File: rtl/sc_mult_ctrl.sv
// Stochastic-computing multiply sequencer: latches two unsigned operands, runs an
// 8-bit LFSR for STREAM_LEN cycles, compares and ANDs the streams, and counts the ones.
`timescale 1ns/1ps
module sc_mult_ctrl #(
  parameter int unsigned STREAM_LEN = 255,
  parameter logic [7:0]  SEED       = 8'hFF,
  parameter int unsigned CNT_W      = $clog2(STREAM_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_a,
  input  logic [7:0]       in_b,
  output logic             sc_bit_a,
  output logic             sc_bit_b,
  output logic             sc_bit_valid,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] out_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CYC = CNT_W'(STREAM_LEN - 1);
  localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

  state_t           state_r;
  state_t           state_s;
  logic [7:0]       lfsr_r;
  logic [7:0]       a_r;
  logic [7:0]       b_r;
  logic [CNT_W-1:0] cyc_r;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] out_count_r;
  logic             accept_s;
  logic             last_s;
  logic             run_s;
  logic             bit_a_s;
  logic             bit_b_s;
  logic             hit_s;
  logic [CNT_W-1:0] cnt_next_s;

  function automatic logic [7:0] lfsr_step(input logic [7:0] r);
    return {r[6:0], r[7] ^ r[5]};
  endfunction

  // The B comparison uses a nibble-swapped LFSR value so the two streams decorrelate.
  function automatic logic [7:0] nib_swap(input logic [7:0] r);
    return {r[3:0], r[7:4]};
  endfunction

  // Next-state decode for the IDLE/RUN/DONE sequencer.
  always_comb begin
    state_s  = state_r;
    accept_s = 1'b0;
    last_s   = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (in_valid) begin
          accept_s = 1'b1;
          state_s  = S_RUN;
        end else begin
          state_s  = S_IDLE;
        end
      end
      S_RUN: begin
        last_s = (cyc_r == LAST_CYC);
        if (last_s) begin
          state_s = S_DONE;
        end else begin
          state_s = S_RUN;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_s = S_IDLE;
        end else begin
          state_s = S_DONE;
        end
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase
  end

  assign run_s      = (state_r == S_RUN);
  assign bit_a_s    = run_s && (a_r > lfsr_r);
  assign bit_b_s    = run_s && (b_r > nib_swap(lfsr_r));
  assign hit_s      = bit_a_s & bit_b_s;
  assign cnt_next_s = cnt_r + CNT_W'(hit_s);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Operand latch, LFSR, cycle/ones counters and result register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r         <= 8'h00;
      b_r         <= 8'h00;
      lfsr_r      <= SEED;
      cyc_r       <= '0;
      cnt_r       <= '0;
      out_count_r <= '0;
    end else if (accept_s) begin
      a_r    <= in_a;
      b_r    <= in_b;
      lfsr_r <= SEED;
      cyc_r  <= '0;
      cnt_r  <= '0;
    end else if (run_s) begin
      lfsr_r <= lfsr_step(lfsr_r);
      cyc_r  <= cyc_r + ONE_CNT;
      cnt_r  <= cnt_next_s;
      // The final RUN cycle's bit must be included in the published result.
      if (last_s) begin
        out_count_r <= cnt_next_s;
      end else begin
        out_count_r <= out_count_r;
      end
    end else begin
      lfsr_r <= lfsr_r;
    end
  end

  assign in_ready     = (state_r == S_IDLE);
  assign busy         = (state_r == S_RUN) || (state_r == S_DONE);
  assign out_valid    = (state_r == S_DONE);
  assign sc_bit_valid = run_s;
  assign sc_bit_a     = bit_a_s;
  assign sc_bit_b     = bit_b_s;
  assign out_count    = out_count_r;

endmodule

// File: tb/tb_sc_mult_ctrl.sv
// Self-checking bench for sc_mult_ctrl: directed and random operations checked against
// an arithmetic model of the LFSR / compare / AND / count behaviour.
`timescale 1ns/1ps
module tb_sc_mult_ctrl;

  localparam int         LEN  = 255;
  localparam int         CW   = 8;
  localparam logic [7:0] SEED = 8'hFF;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0, out_ready = 1'b0;
  logic [7:0]    in_a = 8'h00, in_b = 8'h00;
  logic          in_ready, sc_bit_a, sc_bit_b, sc_bit_valid, busy, out_valid;
  logic [CW-1:0] out_count;

  logic          in_valid1 = 1'b0, out_ready1 = 1'b0;
  logic [7:0]    in_a1 = 8'h00, in_b1 = 8'h00;
  logic          in_ready1, sc_bit_a1, sc_bit_b1, sc_bit_valid1, busy1, out_valid1;
  logic [0:0]    out_count1;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sc_mult_ctrl #(.STREAM_LEN(LEN), .SEED(SEED)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .sc_bit_a(sc_bit_a), .sc_bit_b(sc_bit_b),
    .sc_bit_valid(sc_bit_valid), .busy(busy), .out_valid(out_valid),
    .out_ready(out_ready), .out_count(out_count));

  sc_mult_ctrl #(.STREAM_LEN(1), .SEED(SEED)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_a(in_a1), .in_b(in_b1), .sc_bit_a(sc_bit_a1), .sc_bit_b(sc_bit_b1),
    .sc_bit_valid(sc_bit_valid1), .busy(busy1), .out_valid(out_valid1),
    .out_ready(out_ready1), .out_count(out_count1));

  function automatic int next_r(input int r);
    return ((r << 1) & 255) | (((r >> 7) ^ (r >> 5)) & 1);
  endfunction

  function automatic int swap_r(input int r);
    return ((r & 15) << 4) | ((r >> 4) & 15);
  endfunction

  function automatic int golden(input int a, input int b, input int len);
    int r;
    int c;
    r = SEED;
    c = 0;
    for (int i = 0; i < len; i++) begin
      if (a > r && b > swap_r(r)) c++;
      r = next_r(r);
    end
    return c;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Starts at a negedge in IDLE; returns at a negedge (IDLE if ack, else DONE).
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input bit ack, output int got);
    int cyc;
    int bad;
    int r;
    check("idle_in_ready", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1; in_a = a; in_b = b;
    @(negedge clk);
    in_valid = 1'b0; in_a = 8'($urandom); in_b = 8'($urandom);
    cyc = 1; r = SEED; bad = 0;
    while (out_valid !== 1'b1 && cyc < 400) begin
      if (sc_bit_valid !== 1'b1 || busy !== 1'b1 || in_ready !== 1'b0 ||
          sc_bit_a !== (int'(a) > r) || sc_bit_b !== (int'(b) > swap_r(r))) bad++;
      r = next_r(r);
      @(negedge clk);
      cyc++;
    end
    check("latency", cyc, LEN + 1);
    check("run_bits", bad, 0);
    check("count", {24'd0, out_count}, golden(a, b, LEN));
    check("done_flags", {29'd0, in_ready, busy, sc_bit_valid}, 32'd2);
    got = int'(out_count);
    if (ack) begin
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check("ack_idle", {29'd0, out_valid, in_ready, busy}, 32'd2);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int got, got2, bad, spur, nres, cyc, last_acc;
    int qa[$];
    int qb[$];
    int acc[$];
    logic [7:0] a, b;

    repeat (3) @(negedge clk);
    check("rst_outputs", {26'd0, out_valid, busy, sc_bit_valid, sc_bit_a, sc_bit_b, 1'b0}, 32'd0);
    check("rst_count", {24'd0, out_count}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // STREAM_LEN=1: one RUN cycle with r=FF, so even 255 gives bit 0.
    in_valid1 = 1'b1; in_a1 = 8'd255; in_b1 = 8'd255;
    @(negedge clk);
    in_valid1 = 1'b0;
    check("len1_run", {27'd0, sc_bit_valid1, sc_bit_a1, sc_bit_b1, out_valid1, in_ready1}, 32'h10);
    @(negedge clk);
    check("len1_done", {29'd0, out_valid1, busy1, out_count1}, 32'h6);
    out_ready1 = 1'b1;
    @(negedge clk);
    out_ready1 = 1'b0;
    check("len1_idle", {30'd0, out_valid1, in_ready1}, 32'd1);

    // Operand A = 0 never produces a one.
    run_op(8'd0, 8'd200, 1'b1, got);
    check("zero_a_count", got, 0);

    // Identical requests reproduce the same count thanks to the reseed.
    run_op(8'd180, 8'd90, 1'b1, got);
    run_op(8'd180, 8'd90, 1'b1, got2);
    check("repeat_same", got2, got);

    for (int i = 0; i < 200; i++) begin
      a = 8'($urandom);
      b = 8'($urandom);
      if (i == 0) begin a = 8'd255; b = 8'd255; end
      run_op(a, b, 1'b1, got);
    end

    // Backpressure: DONE holds with stable outputs while in_valid is ignored.
    run_op(8'd200, 8'd150, 1'b0, got);
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      in_valid = (i % 7 == 0); in_a = 8'($urandom); in_b = 8'($urandom);
      @(negedge clk);
      if (out_valid !== 1'b1 || int'(out_count) != got || in_ready !== 1'b0 || busy !== 1'b1) bad++;
    end
    in_valid = 1'b0;
    check("backpressure_stable", bad, 0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_release", {30'd0, out_valid, in_ready}, 32'd1);
    run_op(8'd77, 8'd240, 1'b1, got);

    // Asynchronous reset in RUN cycle 100.
    in_valid = 1'b1; in_a = 8'd250; in_b = 8'd250;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (99) @(negedge clk);
    check("pre_reset_run", {31'd0, sc_bit_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_flags", {27'd0, out_valid, busy, sc_bit_valid, sc_bit_a, sc_bit_b}, 32'd0);
    check("async_rst_count", {24'd0, out_count}, 32'd0);
    check("async_rst_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    spur = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || in_ready !== 1'b1) spur++;
    end
    check("no_spurious_valid", spur, 0);
    run_op(8'd123, 8'd231, 1'b1, got);

    // Back-to-back with in_valid and out_ready tied high.
    in_valid = 1'b1; out_ready = 1'b1;
    nres = 0; cyc = 0; bad = 0; spur = 0;
    while (nres < 4 && cyc < 4 * (LEN + 2) + 50) begin
      if (in_ready === 1'b1 && out_valid === 1'b1) spur++;
      if (out_valid === 1'b1) begin
        if (qa.size() == 0 || int'(out_count) != golden(qa[0], qb[0], LEN)) bad++;
        if (qa.size() != 0) begin void'(qa.pop_front()); void'(qb.pop_front()); end
        nres++;
      end
      if (in_ready === 1'b1) begin
        in_a = 8'($urandom); in_b = 8'($urandom);
        qa.push_back(int'(in_a)); qb.push_back(int'(in_b));
        acc.push_back(cyc);
      end
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    check("b2b_results", nres, 4);
    check("b2b_counts", bad, 0);
    check("b2b_ready_vs_valid", spur, 0);
    bad = 0;
    last_acc = -1;
    foreach (acc[i]) begin
      if (last_acc >= 0 && acc[i] - last_acc != LEN + 2) bad++;
      last_acc = acc[i];
    end
    check("b2b_spacing", bad, 0);
    check("b2b_accepts", {31'd0, acc.size() >= 4}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/sc_mult_ctrl.md
Name: sc_mult_ctrl

Overview:
- Sequences one stochastic-computing multiply per request.
- Accepts two 8-bit unsigned operands over a valid/ready handshake and drives an internal 8-bit LFSR for STREAM_LEN cycles.
- Each cycle it generates one stochastic bit per operand by comparison, ANDs the two bits, and counts the ones.
- The count is returned over a valid/ready handshake. The block sits between binary-domain logic and the SC datapath, and exposes the raw bitstreams for downstream SC units.

Parameters:
- STREAM_LEN, 255, bitstream length in cycles per operation; legal range 1..1023.
- SEED, 8'hFF, LFSR value loaded at reset and at every accepted start; must be nonzero.
- CNT_W, $clog2(STREAM_LEN+1), width of the count and of the cycle counter; derived, not overridden.

Ports:
- clk  in  1  the single clock; all state updates on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept operands (high only in IDLE).
- in_a  in  8  operand A, unsigned; probability a/256.
- in_b  in  8  operand B, unsigned; probability b/256.
- sc_bit_a  out  1  stochastic bit of A for the current RUN cycle.
- sc_bit_b  out  1  stochastic bit of B for the current RUN cycle.
- sc_bit_valid  out  1  high during RUN cycles only.
- busy  out  1  high in RUN and DONE.
- out_valid  out  1  result valid (DONE state).
- out_ready  in  1  consumer accepts result.
- out_count  out  CNT_W  number of cycles in which sc_bit_a & sc_bit_b was 1.

Behaviour:
Reset (rst_n=0, asynchronous, any state):
- state=IDLE, lfsr=SEED, operand regs=0, cycle counter=0.
- out_count=0, out_valid=0, sc_bit_*=0, sc_bit_valid=0, busy=0, in_ready=1 after release.
- Reset mid-RUN or mid-DONE abandons the operation; no result is produced.

LFSR step: lfsr <= {lfsr[6:0], lfsr[7]^lfsr[5]}. The LFSR advances only in RUN.

States:
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: latch in_a and in_b, lfsr<=SEED, count<=0, cyc<=0, go to RUN.
  - Output registers are otherwise unchanged; out_count keeps its last value.
- RUN: in_ready=0, busy=1, sc_bit_valid=1. Each cycle, with r = current lfsr:
  - sc_bit_a = (a_reg > r).
  - sc_bit_b = (b_reg > {r[3:0], r[7:4]}); the nibble swap decorrelates the two streams.
  - sc_bit_a and sc_bit_b are combinational from registered state and valid in the same cycle.
  - count += sc_bit_a & sc_bit_b.
  - lfsr steps and cyc += 1.
  - When cyc == STREAM_LEN-1 this cycle, go to DONE.
  - RUN lasts exactly STREAM_LEN cycles. The first RUN cycle uses r=SEED.
- DONE:
  - out_valid=1, out_count stable, busy=1, in_ready=0.
  - On out_ready go to IDLE; out_valid drops the next cycle.
  - Backpressure (out_ready=0) holds DONE indefinitely with all outputs stable.

Timing and corner cases:
- Latency: start accepted at edge T. RUN cycles are T+1..T+STREAM_LEN. out_valid rises in cycle T+STREAM_LEN+1.
- Throughput is at most one operation per STREAM_LEN+2 cycles. in_ready is never high in the same cycle as out_valid.
- in_valid outside IDLE is ignored. Operand inputs may change freely after acceptance.
- Count never exceeds STREAM_LEN, so no overflow or saturation is needed.
- Operand 0 always gives bit 0. Operand 255 gives bit 1 unless r (or its swap) is 8'hFF.
- STREAM_LEN=1: exactly one RUN cycle.

Test Plan:
- Reset then in_a=0, in_b=200, STREAM_LEN=255 -> out_valid rises exactly 256 cycles after the accept edge; out_count=0; sc_bit_a=0 in all 255 RUN cycles.
- in_a=255, in_b=255, SEED=8'hFF, STREAM_LEN=1 -> single RUN cycle with r=FF; sc_bit_a=sc_bit_b=0; out_count=0.
- Random pairs (≥200), STREAM_LEN=255 -> out_count equals a bit-exact golden model of the LFSR/compare/AND. Two identical requests give identical counts because of the reseed.
- out_ready held low 50 cycles in DONE; in_valid pulsed meanwhile -> out_valid and out_count stable, in_ready=0, request not accepted. out_ready=1 returns to IDLE, and the next in_valid is accepted.
- Assert rst_n low asynchronously (between clock edges) in RUN cycle 100 -> all outputs go to reset values immediately. After release: IDLE, in_ready=1, lfsr=SEED, no spurious out_valid.
- Back-to-back ops with out_ready tied high, in_valid tied high -> accepts spaced exactly STREAM_LEN+2 cycles apart; each count matches the golden model.
